serial_add32_ctrl: RTL and testbench
====================================

SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

Interface
REQ-001 SHALL have parameter SLICE_W, default 8, meaning adder slice width in bits; legal values are 4, 8 and 16.
REQ-002 SHALL define N = 32/SLICE_W as the number of slices per operation; N is 4 at the default.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operands a, b and ci are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-008 SHALL have port a, input, 32 bits: addend.
REQ-009 SHALL have port b, input, 32 bits: addend.
REQ-010 SHALL have port ci, input, 1 bit: carry in.
REQ-011 SHALL have port out_valid, output, 1 bit: s, co and ovf hold a valid result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port s, output, 32 bits: sum.
REQ-014 SHALL have port co, output, 1 bit: carry out of bit 31.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement overflow.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL implement exactly one SLICE_W-bit adder and reuse it over N cycles, from the LSB slice to the MSB slice.
REQ-018 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-019 SHALL drive in_ready high only in IDLE; out_valid only in DONE; busy in RUN and DONE.
REQ-020 IDLE: when in_valid is high at a clock edge, SHALL capture a, b and ci, load the carry register with ci, clear slice counter cnt, and go to RUN.
REQ-021 RUN: each clock edge SHALL write slice cnt of s as a_slice + b_slice + carry_reg, store the slice carry-out in carry_reg, and increment cnt.
REQ-022 RUN: on the edge where cnt = N-1, SHALL set co to the carry out of bit 31 and ovf to carry-into-bit-31 XOR carry-out-of-bit-31, then go to DONE.
REQ-023 DONE: SHALL go to IDLE on the edge where out_ready is high; otherwise SHALL stay in DONE.
REQ-024 SHALL raise out_valid exactly N clock edges after the accepting edge.
REQ-025 SHALL give a back-to-back throughput of one operation per N+2 cycles, with in_valid and out_ready held high.
REQ-026 SHALL keep s, co and ovf stable while out_valid is high, independent of the a, b, ci and in_valid inputs.
REQ-027 SHALL hold s, co and ovf at the last result after the DONE handshake until the next RUN overwrites them.
REQ-028 SHALL ignore in_valid in RUN and DONE, with no queuing and no capture.
REQ-029 SHALL ignore out_ready in IDLE and RUN.
REQ-030 SHALL compute arithmetic modulo 2^32; no bits beyond co and ovf are produced.
REQ-031 SHALL compute ovf from the full 33-bit result path; it is valid only while out_valid is high.

Reset
REQ-032 SHALL, while rst is high at a clock edge, force state IDLE, cnt = 0, carry_reg = 0, s = 0, co = 0 and ovf = 0, with priority over all other events.
REQ-033 SHALL give out_valid = 0, busy = 0 and in_ready = 1 in the cycle after reset.
REQ-034 SHALL, on reset during RUN or DONE, discard the operation; no partial result becomes valid.

Verification
REQ-035 SHALL cover: a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, co=1, ovf=0, with out_valid 4 edges after accept at SLICE_W=8.
REQ-036 SHALL cover: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1.
REQ-037 SHALL cover: a=0x000000FF, b=0, ci=1 -> s=0x00000100, co=0, confirming the carry crosses the slice boundary through carry_reg.
REQ-038 SHALL cover: out_ready held low 10 cycles in DONE, in_valid high with new operands -> s, co and ovf unchanged, in_ready=0, no capture.
REQ-039 SHALL cover: rst pulsed on the 2nd RUN edge -> next cycle IDLE, s=0, out_valid=0; the following 0x12345678+0x11111111 gives s=0x23456789.
REQ-040 SHALL cover: in_valid and out_ready held high with random operands -> accepts spaced 6 cycles apart at SLICE_W=8, every result matching a reference add; repeated at SLICE_W=4 (10 cycles) and SLICE_W=16 (4 cycles).

Source files
------------

// File: rtl/serial_add32_ctrl.sv
// serial_add32_ctrl: 32-bit adder that reuses a single SLICE_W-bit slice adder
// over N = 32/SLICE_W cycles, least significant slice first, behind a
// valid/ready handshake on both the operand and the result side.
module serial_add32_ctrl #(
    parameter int SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        co,
    output logic        ovf,
    output logic        busy
);
    localparam int N     = 32 / SLICE_W;
    localparam int SH    = $clog2(SLICE_W);
    // cnt concatenated with SH zero bits forms the 5-bit slice base index.
    localparam int CNT_W = 5 - SH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic [31:0]        s_r;
    logic               carry_r;
    logic               co_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [4:0]         lo_s;
    logic [SLICE_W-1:0] a_sl_s;
    logic [SLICE_W-1:0] b_sl_s;
    logic [SLICE_W:0]   sum_s;
    logic               msb_cin_s;
    logic               last_s;

    // Slice adder: pick slice cnt of the captured operands and add the running carry.
    always_comb begin
        lo_s      = {cnt_r, {SH{1'b0}}};
        a_sl_s    = a_r[lo_s +: SLICE_W];
        b_sl_s    = b_r[lo_s +: SLICE_W];
        sum_s     = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE_W{1'b0}}, carry_r};
        // Carry into the top bit of the slice; on the last slice this is the carry into bit 31.
        msb_cin_s = a_sl_s[SLICE_W-1] ^ b_sl_s[SLICE_W-1] ^ sum_s[SLICE_W-1];
        last_s    = (cnt_r == CNT_W'(N - 1));
    end

    // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake/status flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Datapath: capture operands in IDLE, build the sum one slice per cycle in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            s_r     <= 32'd0;
            carry_r <= 1'b0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_W'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= ci;
                        cnt_r   <= CNT_W'(0);
                    end
                end
                RUN: begin
                    s_r[lo_s +: SLICE_W] <= sum_s[SLICE_W-1:0];
                    carry_r              <= sum_s[SLICE_W];
                    cnt_r                <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        co_r  <= sum_s[SLICE_W];
                        ovf_r <= msb_cin_s ^ sum_s[SLICE_W];
                    end
                end
                DONE: begin
                    // Result held stable until the consumer takes it.
                end
                default: begin
                    // Unreachable encoding; no datapath update.
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign s         = s_r;
    assign co        = co_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add32_ctrl.sv
// Testbench for serial_add32_ctrl: three instances (SLICE_W = 4, 8, 16) share
// the same stimulus. Directed table vectors and corner sequences check the
// SLICE_W=8 instance; a randomized back-to-back phase checks all three against
// a plain 33-bit arithmetic reference model.
module tb_serial_add32_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  co_v;
    logic [2:0]  ovf_v;
    logic [2:0]  busy_v;
    logic [31:0] s_v [3];

    int n_tests;
    int n_fail;
    int cyc;

    logic [64:0] pend [3];
    logic [2:0]  pend_v;
    logic [2:0]  prev_ov;
    int          last_acc [3];
    int          results [3];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];

    serial_add32_ctrl #(.SLICE_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .s(s_v[0]), .co(co_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0])
    );

    serial_add32_ctrl #(.SLICE_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .s(s_v[1]), .co(co_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1])
    );

    serial_add32_ctrl #(.SLICE_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .s(s_v[2]), .co(co_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2])
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time accepts and results.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    function automatic int n_of(input int k);
        if (k == 0) return 8;
        else if (k == 1) return 4;
        else return 2;
    endfunction

    // Reference: full-width add; overflow when both addends share a sign the sum lacks.
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        logic [32:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        v = (x[31] == y[31]) && (t[31] != x[31]);
        return {v, t};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one operation to the SLICE_W=8 instance from IDLE and count edges to out_valid.
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                         output int lat);
        a         = oa;
        b         = ob;
        ci        = oc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_v[1] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Per-instance scoreboard step, sampled at the falling edge.
    task automatic monitor(input int k);
        logic [33:0] e;
        if (in_ready_v[k] && in_valid) begin
            if (last_acc[k] >= 0) begin
                check($sformatf("spacing_w%0d", 32 / n_of(k)), 64'(cyc + 1 - last_acc[k]),
                      64'(n_of(k) + 2));
            end
            last_acc[k] = cyc + 1;
            pend[k]     = {ci, b, a};
            pend_v[k]   = 1'b1;
        end
        if (out_valid_v[k] && !prev_ov[k]) begin
            check($sformatf("latency_w%0d", 32 / n_of(k)), 64'(cyc - last_acc[k]),
                  64'(n_of(k)));
        end
        if (out_valid_v[k] && out_ready) begin
            check($sformatf("pending_w%0d", 32 / n_of(k)), 64'(pend_v[k]), 64'(1));
            e = ref_add(pend[k][31:0], pend[k][63:32], pend[k][64]);
            check($sformatf("rand_result_w%0d", 32 / n_of(k)),
                  64'({ovf_v[k], co_v[k], s_v[k]}), 64'(e));
            pend_v[k] = 1'b0;
            results[k]++;
        end
        prev_ov[k] = out_valid_v[k];
    endtask

    initial begin
        int lat;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        ci        = 1'b0;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
        vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};

        // Reset state on every instance.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_flags_%0d", k),
                  64'({in_ready_v[k], out_valid_v[k], busy_v[k]}), 64'(3'b100));
            check($sformatf("reset_result_%0d", k),
                  64'({ovf_v[k], co_v[k], s_v[k]}), 64'd0);
        end

        // Table-driven directed vectors on the SLICE_W=8 instance.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_result", i), 64'({ovf_v[1], co_v[1], s_v[1]}),
                  64'({vecs[i].ovf, vecs[i].co, vecs[i].s}));
            release_result();
            check($sformatf("vec%0d_idle", i), 64'({in_ready_v[1], out_valid_v[1], busy_v[1]}),
                  64'(3'b100));
        end

        // Result held in DONE while out_ready is low and new operands are offered.
        do_op(32'h0000FFFF, 32'h00000001, 1'b0, lat);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("hold_result", 64'({ovf_v[1], co_v[1], s_v[1]}), 64'({2'b00, 32'h00010000}));
            check("hold_flags", 64'({in_ready_v[1], out_valid_v[1]}), 64'(2'b01));
        end
        in_valid = 1'b0;
        release_result();
        check("after_ack_flags", 64'({in_ready_v[1], out_valid_v[1]}), 64'(2'b10));
        check("after_ack_held", 64'(s_v[1]), 64'(32'h00010000));

        // Reset on the second RUN edge discards the operation.
        a        = 32'hDEADBEEF;
        b        = 32'h01020304;
        ci       = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("run_flags", 64'({in_ready_v[1], busy_v[1]}), 64'(2'b01));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_reset_flags", 64'({in_ready_v[1], out_valid_v[1], busy_v[1]}),
              64'(3'b100));
        check("midrun_reset_s", 64'(s_v[1]), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid_v[1]) check("no_partial_result", 64'(out_valid_v[1]), 64'd0);
        end
        check("still_idle", 64'({in_ready_v[1], out_valid_v[1]}), 64'(2'b10));
        do_op(32'h12345678, 32'h11111111, 1'b0, lat);
        check("post_reset_latency", 64'(lat), 64'd4);
        check("post_reset_result", 64'({ovf_v[1], co_v[1], s_v[1]}),
              64'({2'b00, 32'h23456789}));
        release_result();

        // Randomized back-to-back phase on all three slice widths.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pend[k]     = 65'd0;
            last_acc[k] = -1;
            results[k]  = 0;
        end
        pend_v    = 3'b000;
        prev_ov   = 3'b000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = $urandom;
        b         = $urandom;
        ci        = 1'($urandom_range(0, 1));
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) monitor(k);
            @(posedge clk); #1;
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rand_count_w%0d", 32 / n_of(k)), 64'(results[k] >= 20), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
